uart_bus_master: RTL and testbench

UART-driven bus initiator for loading and inspecting memory over the serial link, alongside the CPU-side UART peripheral. It consumes received bytes from the UART receiver, decodes read and write command frames, and issues single-cycle `memRead`/`memWrite` accesses on the data-memory bus. Replies are returned through the UART transmitter: an ack byte for writes, four data bytes for reads. `busy` stalls the CPU while a frame is in progress.

---
 rtl/uart_bus_master_pkg.sv | 10 +
 rtl/uart_frame_timer.sv | 21 ++
 rtl/uart_bus_master.sv | 139 +++++++++++++
 tb/tb_uart_bus_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_master_pkg.sv
// uart_bus_master_pkg: frame command/reply codes, FSM states and default timeout
// shared by the UART bus master and its frame timer.
package uart_bus_master_pkg;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] REPLY_ACK = 8'h4B;
    localparam logic [7:0] REPLY_ERR = 8'h3F;
    localparam int DEFAULT_TIMEOUT = 200000;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_SEND, S_WAIT} state_t;
endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: inter-byte idle counter; expired once TIMEOUT_CYCLES enabled
// cycles pass with no clear. Disabled or cleared cycles reset the count.
module uart_frame_timer
    import uart_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] count_q, count_d;
    assign expired = enable && (count_q == W'(TIMEOUT_CYCLES));
    always_comb count_d = (clear || !enable) ? '0 : expired ? count_q : count_q + W'(1);
    always_ff @(posedge clk or posedge rst)
        if (rst) count_q <= '0;
        else count_q <= count_d;
endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: decodes 'W'/'R' frames from the UART receiver into single-cycle
// memory accesses and returns ack/read data through the UART transmitter.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxValid,
    input  logic [7:0]  rxByte,
    output logic        txStart,
    output logic [7:0]  txByte,
    input  logic        txDone,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] address,
    output logic [31:0] dataOut,
    input  logic [31:0] dataIn,
    output logic        busy,
    output logic        overrun
);
    state_t      state_q, state_d;
    logic        is_read_q, is_read_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] address_q, address_d, data_out_q, data_out_d, reply_q, reply_d;
    logic [2:0]  rem_q, rem_d;
    logic        overrun_q, overrun_d, tx_start_q, tx_start_d;
    logic        mem_read_q, mem_write_q, busy_q;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        expired;

    uart_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == S_ADDR || state_q == S_DATA),
        .clear  (rxValid),
        .expired(expired)
    );

    always_comb begin
        state_d    = state_q;
        is_read_d  = is_read_q;
        cnt_d      = cnt_q;
        address_d  = address_q;
        data_out_d = data_out_q;
        reply_d    = reply_q;
        rem_d      = rem_q;
        overrun_d  = overrun_q;
        case (state_q)
            S_IDLE: if (rxValid) begin
                if (rxByte == CMD_WRITE || rxByte == CMD_READ) begin
                    state_d   = S_ADDR;
                    is_read_d = (rxByte == CMD_READ);
                    cnt_d     = 2'd0;
                    overrun_d = 1'b0;
                end else begin
                    state_d = S_SEND;
                    reply_d = {REPLY_ERR, 24'h0};
                    rem_d   = 3'd1;
                end
            end
            // A byte arriving in the expiry cycle wins over the timeout.
            S_ADDR: if (rxValid) begin
                address_d = {address_q[23:0], rxByte};
                cnt_d     = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = is_read_q ? S_READ : S_DATA;
            end else if (expired) state_d = S_IDLE;
            S_DATA: if (rxValid) begin
                data_out_d = {data_out_q[23:0], rxByte};
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_WRITE;
            end else if (expired) state_d = S_IDLE;
            S_WRITE: begin
                reply_d = {REPLY_ACK, 24'h0};
                rem_d   = 3'd1;
                state_d = S_SEND;
            end
            S_READ: begin
                reply_d = dataIn;
                rem_d   = 3'd4;
                state_d = S_SEND;
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: if (txDone) begin
                reply_d = {reply_q[23:0], 8'h0};
                rem_d   = rem_q - 3'd1;
                state_d = (rem_q == 3'd1) ? S_IDLE : S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
        if (rxValid && (state_q == S_WRITE || state_q == S_READ || state_q == S_SEND || state_q == S_WAIT))
            overrun_d = 1'b1;
        tx_start_d = (state_d == S_SEND);
        tx_byte_d  = tx_start_d ? reply_d[31:24] : tx_byte_q;
    end

    // Strobes, txStart and busy are registered off the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_read_q   <= 1'b0;
            cnt_q       <= 2'd0;
            address_q   <= '0;
            data_out_q  <= '0;
            reply_q     <= '0;
            rem_q       <= '0;
            overrun_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            cnt_q       <= cnt_d;
            address_q   <= address_d;
            data_out_q  <= data_out_d;
            reply_q     <= reply_d;
            rem_q       <= rem_d;
            overrun_q   <= overrun_d;
            tx_start_q  <= tx_start_d;
            tx_byte_q   <= tx_byte_d;
            mem_read_q  <= (state_d == S_READ);
            mem_write_q <= (state_d == S_WRITE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign txStart  = tx_start_q;
    assign txByte   = tx_byte_q;
    assign memRead  = mem_read_q;
    assign memWrite = mem_write_q;
    assign address  = address_q;
    assign dataOut  = data_out_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: directed/random frames driven straight onto the byte interface,
// with a frame-level reference model for strobes, bus values and reply bytes.
module tb_uart_bus_master;
    localparam int TO = 50;

    logic        clk = 0;
    logic        rst = 0;
    logic        rxValid = 0;
    logic [7:0]  rxByte = 0;
    logic        txStart;
    logic [7:0]  txByte;
    logic        txDone = 0;
    logic        memRead, memWrite;
    logic [31:0] address, dataOut;
    logic [31:0] rd_data = 0;
    logic        busy, overrun;

    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit both_seen = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    uart_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rxValid(rxValid), .rxByte(rxByte),
        .txStart(txStart), .txByte(txByte), .txDone(txDone),
        .memRead(memRead), .memWrite(memWrite), .address(address),
        .dataOut(dataOut), .dataIn(rd_data), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memWrite === 1'b1) wr_cnt++;
        if (memRead === 1'b1) rd_cnt++;
        if (memRead === 1'b1 && memWrite === 1'b1) both_seen = 1;
        if (txStart === 1'b1) tx_q.push_back(txByte);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        check(tag, {txStart, txByte, memRead, memWrite, address, dataOut, busy, overrun}, 128'h0);
    endtask

    // Called at a negedge; the byte is sampled at the next posedge, returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rxValid = 1;
        rxByte = b;
        @(negedge clk);
        rxValid = 0;
    endtask

    task automatic pulse_done();
        txDone = 1;
        @(negedge clk);
        txDone = 0;
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input bit inject);
        int wr0, rd0, n;
        bit is_w;
        logic [7:0] eb;
        is_w = (cmd == 8'h57);
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        n = is_w ? 1 : 4;
        if (!is_w) rd_data = d;
        send_byte(cmd);
        check("busy_rise", busy, 1);
        check("overrun_clr", overrun, 0);
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
        if (is_w) for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
        check("strobe_hi", {memWrite, memRead}, is_w ? 2'b10 : 2'b01);
        check("address", address, a);
        if (is_w) check("dataOut", dataOut, d);
        @(negedge clk);
        check("strobe_lo", {memWrite, memRead}, 2'b00);
        for (int i = 0; i < n; i++) begin
            eb = is_w ? 8'h4B : d[31-8*i -: 8];
            exp_q.push_back(eb);
            check("tx_start", txStart, 1);
            check("tx_byte", txByte, eb);
            if (inject && i == 0) begin
                @(negedge clk);
                send_byte(8'h57);
                check("overrun_set", overrun, 1);
            end
            repeat (2) @(negedge clk);
            check("tx_idle", txStart, 0);
            check("tx_hold", txByte, eb);
            check("busy_wait", busy, 1);
            pulse_done();
        end
        check("busy_fall", busy, 0);
        check("tx_after", txStart, 0);
        check("address_hold", address, a);
        check("wr_count", wr_cnt - wr0, is_w ? 1 : 0);
        check("rd_count", rd_cnt - rd0, is_w ? 0 : 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra, rd;
        int tx0, wr0, rd0;
        #2 rst = 1;
        #1 all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        all_zero("post_reset");

        do_frame(8'h57, 32'h40000018, 32'h000000A5, 0);
        do_frame(8'h52, 32'h00000010, 32'hDEADBEEF, 0);
        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rd = $urandom;
            do_frame(8'h57, ra, rd, 0);
            ra = $urandom;
            rd = $urandom;
            do_frame(8'h52, ra, rd, 0);
        end

        // Unknown command
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        send_byte(8'h13);
        exp_q.push_back(8'h3F);
        check("unk_start", txStart, 1);
        check("unk_byte", txByte, 8'h3F);
        check("unk_busy", busy, 1);
        repeat (2) @(negedge clk);
        pulse_done();
        check("unk_done", busy, 0);
        check("unk_nostrobe", (wr_cnt - wr0) + (rd_cnt - rd0), 0);

        // Timeout after 3 address bytes
        tx0 = tx_q.size();
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        send_byte(8'h57);
        for (int i = 0; i < 3; i++) send_byte(8'h11 * (i + 1));
        repeat (TO - 1) @(negedge clk);
        check("to_not_yet", busy, 1);
        repeat (4) @(negedge clk);
        check("to_idle", busy, 0);
        check("to_nostrobe", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
        check("to_noreply", tx_q.size() - tx0, 0);
        do_frame(8'h52, 32'h00000020, 32'h0BADF00D, 0);

        // Byte arriving in the same cycle the timer expires is still accepted
        rd_data = 32'h12345678;
        send_byte(8'h52);
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
        repeat (TO) @(negedge clk);
        send_byte(8'hA3);
        check("to_edge_read", memRead, 1);
        check("to_edge_addr", address, 32'hA0A1A2A3);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(rd_data[31-8*i -: 8]);
            check("to_edge_tx", txByte, rd_data[31-8*i -: 8]);
            @(negedge clk);
            pulse_done();
        end
        check("to_edge_busy", busy, 0);

        // Overrun during read reply, cleared by the next command
        do_frame(8'h52, $urandom, $urandom, 1);
        check("overrun_sticky", overrun, 1);
        do_frame(8'h57, $urandom, $urandom, 0);

        // Reset during DATA
        send_byte(8'h57);
        for (int i = 0; i < 6; i++) send_byte(8'h5A);
        rst = 1;
        #1 all_zero("rst_data");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        all_zero("rst_data_after");

        // Reset during WAIT, then a stray txDone
        rd_data = 32'hCAFE0001;
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        @(negedge clk);
        exp_q.push_back(8'hCA);
        @(negedge clk);
        check("wait_busy", busy, 1);
        rst = 1;
        #1 all_zero("rst_wait");
        @(negedge clk);
        rst = 0;
        tx0 = tx_q.size();
        pulse_done();
        repeat (3) @(negedge clk);
        check("stray_done", tx_q.size() - tx0, 0);
        all_zero("stray_idle");
        do_frame(8'h57, 32'h40000000, 32'h00000001, 0);

        check("never_both", both_seen, 0);
        check("reply_count", tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            check($sformatf("reply_%0d", i), tx_q[i], exp_q[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
